muldiv_sequencer: RTL and testbench

Multi-cycle controller for the processor's signed multiply and divide instructions, which are opcode 1111 with function codes 0100 and 1000. It sits beside the EX stage. It accepts operands when the instruction issues, stalls the pipeline while it runs an iterative shift-add or shift-subtract over WIDTH cycles, and then presents two results for one cycle:
- a low half or quotient for the destination register;
- a high half or remainder for R0.

Divide-by-zero and divide overflow are reported on a flag that the control unit ORs into its overflow halt path.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_sequencer.sv | 157 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide sequencer
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [3:0] FC_MUL = 4'b0100;
  localparam logic [3:0] FC_DIV = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one unsigned shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] word_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] word_out
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // Multiply keeps the carry of acc + multiplicand so it can shift into the pair;
  // divide brings the next dividend bit into the remainder and trial-subtracts.
  always_comb begin
    mul_sum   = {1'b0, acc_in} + (word_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    rem_shift = {acc_in, word_in[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, operand});
    // When the subtract fits the result is below the divisor, so the low bits are exact.
    trial     = rem_shift[WIDTH-1:0] - operand;
    if (is_div) begin
      acc_out  = fits ? trial : rem_shift[WIDTH-1:0];
      word_out = {word_in[WIDTH-2:0], fits};
    end else begin
      acc_out  = mul_sum[WIDTH:1];
      word_out = {mul_sum[0], word_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle signed multiply/divide controller beside the EX stage
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       function_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             arith_error
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] operand;
  logic [CW-1:0]    cnt;

  logic             fc_valid;
  logic             fc_div;
  logic             accept;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_word;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Accept decode, operand magnitudes, error detection and the stall/busy handshake.
  always_comb begin
    fc_div   = (function_code == FC_DIV);
    fc_valid = (function_code == FC_MUL) || fc_div;
    accept   = (state == IDLE) && start && fc_valid && !flush;
    stall    = accept || (state == CALC) || (state == FIXUP);
    busy     = (state != IDLE);
    abs_a    = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    abs_b    = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
    div_zero = (op_b == {WIDTH{1'b0}});
    div_ovf  = (op_a == MOST_NEG) && (op_b == {WIDTH{1'b1}});
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc_in   (acc),
    .word_in  (word),
    .operand  (operand),
    .acc_out  (step_acc),
    .word_out (step_word)
  );

  // Sign fix-up: product {acc, word} as one 2*WIDTH value; quotient in word, remainder in acc.
  always_comb begin
    prod_fix = neg_lo ? (~{acc, word} + 1'b1) : {acc, word};
    quo_fix  = neg_lo ? (~word + 1'b1) : word;
    rem_fix  = neg_hi ? (~acc + 1'b1) : acc;
  end

  // Sequencer FSM with the iteration counter and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      acc         <= '0;
      word        <= '0;
      operand     <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      arith_error <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      done        <= 1'b0;
      arith_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done        <= 1'b0;
          arith_error <= 1'b0;
          if (accept) begin
            is_div  <= fc_div;
            neg_lo  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            neg_hi  <= op_a[WIDTH-1];
            acc     <= '0;
            word    <= fc_div ? abs_a : abs_b;
            operand <= fc_div ? abs_b : abs_a;
            cnt     <= '0;
            if (fc_div && div_zero) begin
              state       <= DONE;
              done        <= 1'b1;
              result_lo   <= '1;
              result_hi   <= op_a;
              arith_error <= 1'b1;
            end else if (fc_div && div_ovf) begin
              state       <= DONE;
              done        <= 1'b1;
              result_lo   <= MOST_NEG;
              result_hi   <= '0;
              arith_error <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc  <= step_acc;
          word <= step_word;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          if (is_div) begin
            result_lo <= quo_fix;
            result_hi <= rem_fix;
          end else begin
            result_lo <= prod_fix[WIDTH-1:0];
            result_hi <= prod_fix[2*WIDTH-1:WIDTH];
          end
          done        <= 1'b1;
          arith_error <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          done        <= 1'b0;
          arith_error <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer with a behavioural model
module tb_muldiv_sequencer;

  localparam logic [3:0] MUL = 4'b0100;
  localparam logic [3:0] DIV = 4'b1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  function_code;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic        arith_error;

  int vectors = 0;
  int miscompares = 0;

  muldiv_sequencer #(.WIDTH(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .function_code (function_code),
    .op_a          (op_a),
    .op_b          (op_b),
    .flush         (flush),
    .stall         (stall),
    .busy          (busy),
    .done          (done),
    .result_lo     (result_lo),
    .result_hi     (result_hi),
    .arith_error   (arith_error)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed arithmetic with truncating division, plus the two error cases.
  function automatic void model(input logic [3:0] fc, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] lo, output logic [15:0] hi,
                                output logic err, output int lat);
    int sa, sb, p, q, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (fc == MUL) begin
      p = sa * sb;
      lo = p[15:0]; hi = p[31:16]; err = 1'b0; lat = 18;
    end else if (b == 16'h0000) begin
      lo = 16'hFFFF; hi = a; err = 1'b1; lat = 1;
    end else if (a == 16'h8000 && b == 16'hFFFF) begin
      lo = 16'h8000; hi = 16'h0000; err = 1'b1; lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      lo = q[15:0]; hi = r[15:0]; err = 1'b0; lat = 18;
    end
  endfunction

  // Issues one operation and waits for done; reports latency, results and stall behaviour.
  task automatic do_op(input logic [3:0] fc, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [15:0] lo, output logic [15:0] hi,
                       output logic err, output logic stall_ok);
    stall_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; function_code = fc; op_a = a; op_b = b;
    #1;
    if (stall !== 1'b1) stall_ok = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (stall !== 1'b0) stall_ok = 1'b0;
    lo = result_lo; hi = result_hi; err = arith_error;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0; function_code = 4'h0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({stall, busy, done, arith_error, result_lo, result_hi} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got stall=%b busy=%b done=%b err=%b lo=%h hi=%h, expected all zero",
               stall, busy, done, arith_error, result_lo, result_hi);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({stall, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_after_reset: got stall=%b busy=%b done=%b, expected 000", stall, busy, done);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  t_fc  [10] = '{MUL, MUL, DIV, DIV, DIV, DIV, MUL, DIV, MUL, DIV};
    logic [15:0] t_a   [10] = '{16'h0003, 16'h7FFF, 16'hFFF9, 16'h0005, 16'h8000,
                                16'h8000, 16'h8000, 16'h0007, 16'h0000, 16'h0000};
    logic [15:0] t_b   [10] = '{16'hFFFC, 16'h7FFF, 16'h0002, 16'h0000, 16'hFFFF,
                                16'h0001, 16'h8000, 16'hFFFE, 16'hFFFF, 16'h0000};
    logic [15:0] t_lo  [10] = '{16'hFFF4, 16'h0001, 16'hFFFD, 16'hFFFF, 16'h8000,
                                16'h8000, 16'h0000, 16'hFFFD, 16'h0000, 16'hFFFF};
    logic [15:0] t_hi  [10] = '{16'hFFFF, 16'h3FFF, 16'hFFFF, 16'h0005, 16'h0000,
                                16'h0000, 16'h4000, 16'h0001, 16'h0000, 16'h0000};
    logic        t_err [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          t_lat [10] = '{18, 18, 18, 1, 1, 18, 18, 18, 18, 1};
    int lat; logic [15:0] lo, hi; logic err, sok;
    for (int i = 0; i < 10; i++) begin
      do_op(t_fc[i], t_a[i], t_b[i], lat, lo, hi, err, sok);
      vectors++;
      if (lat !== t_lat[i] || lo !== t_lo[i] || hi !== t_hi[i] || err !== t_err[i]) begin
        miscompares++;
        $display("FAIL directed_%0d: got lat=%0d lo=%h hi=%h err=%b, expected lat=%0d lo=%h hi=%h err=%b",
                 i, lat, lo, hi, err, t_lat[i], t_lo[i], t_hi[i], t_err[i]);
      end
      vectors++;
      if (sok !== 1'b1) begin
        miscompares++;
        $display("FAIL directed_stall_%0d: got stall/busy sequence wrong, expected high until done then low", i);
      end
    end
  endtask

  task automatic test_invalid_fc();
    logic [3:0] bad [4] = '{4'b0000, 4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b1; function_code = bad[i]; op_a = 16'h0009; op_b = 16'h0003;
      #1;
      vectors++;
      if (stall !== 1'b0) begin
        miscompares++;
        $display("FAIL invalid_fc_stall_%0d: got stall=%b, expected 0", i, stall);
      end
      @(negedge clk);
      start = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL invalid_fc_busy_%0d: got busy=%b, expected 0", i, busy);
      end
    end
  endtask

  task automatic test_flush();
    int lat; logic [15:0] lo, hi; logic err, sok; int seen_done;
    @(negedge clk);
    start = 1'b1; flush = 1'b1; function_code = MUL; op_a = 16'h0004; op_b = 16'h0005;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_with_start_stall: got stall=%b, expected 0", stall);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_with_start_busy: got busy=%b, expected 0", busy);
    end
    start = 1'b1; function_code = MUL; op_a = 16'h1234; op_b = 16'h0777;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_mid_mul: got busy=%b stall=%b at cycle 9, expected 0 0", busy, stall);
    end
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) seen_done++;
      @(negedge clk);
    end
    vectors++;
    if (seen_done !== 0) begin
      miscompares++;
      $display("FAIL flush_no_done: got %0d done cycles, expected 0", seen_done);
    end
    do_op(MUL, 16'h0006, 16'h0007, lat, lo, hi, err, sok);
    vectors++;
    if (lat !== 18 || lo !== 16'h002A || hi !== 16'h0000 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL after_flush_6x7: got lat=%0d lo=%h hi=%h err=%b, expected lat=18 lo=002a hi=0000 err=0",
               lat, lo, hi, err);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] lo, hi; logic err, sok;
    do_op(DIV, 16'h0064, 16'h0007, lat, lo, hi, err, sok);
    vectors++;
    if (lo !== 16'h000E || hi !== 16'h0002) begin
      miscompares++;
      $display("FAIL b2b_first: got lo=%h hi=%h, expected lo=000e hi=0002", lo, hi);
    end
    start = 1'b1; function_code = MUL; op_a = 16'hFFFA; op_b = 16'h0007;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_done_stall: got stall=%b during DONE, expected 0", stall);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_start_in_done_ignored: got busy=%b stall=%b, expected busy=0 stall=1", busy, stall);
    end
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== 18 || result_lo !== 16'hFFD6 || result_hi !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d lo=%h hi=%h, expected lat=18 lo=ffd6 hi=ffff",
               lat, result_lo, result_hi);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; function_code = DIV; op_a = 16'h1000; op_b = 16'h0003;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({stall, busy, done, arith_error, result_lo, result_hi} !== 36'h0) begin
      miscompares++;
      $display("FAIL async_reset: got stall=%b busy=%b done=%b err=%b lo=%h hi=%h, expected all zero",
               stall, busy, done, arith_error, result_lo, result_hi);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  function automatic logic [15:0] pick_value();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int lat, e_lat; logic [15:0] lo, hi, e_lo, e_hi; logic err, e_err, sok;
    logic [3:0] fc; logic [15:0] a, b;
    for (int i = 0; i < 60; i++) begin
      fc = ($urandom_range(0, 1) == 0) ? MUL : DIV;
      a = pick_value();
      b = pick_value();
      model(fc, a, b, e_lo, e_hi, e_err, e_lat);
      do_op(fc, a, b, lat, lo, hi, err, sok);
      vectors++;
      if (lat !== e_lat || lo !== e_lo || hi !== e_hi || err !== e_err || sok !== 1'b1) begin
        miscompares++;
        $display("FAIL random_%0d fc=%b a=%h b=%h: got lat=%0d lo=%h hi=%h err=%b stall_ok=%b, expected lat=%0d lo=%h hi=%h err=%b stall_ok=1",
                 i, fc, a, b, lat, lo, hi, err, sok, e_lat, e_lo, e_hi, e_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_invalid_fc();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
